// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues the PC as an imem read, collects in-order responses
// into PC-tagged slots and hands {pc, inst} pairs to decode; flush orphans in-flight reads.
module fetch_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic                  fetch_stall_o,
    input  logic                  flush_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [DATA_WIDTH-1:0] inst_pc_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]         PTR_ONE  = 1;
    localparam logic [PW:0]           OCC_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]           SUM_ONE  = 1;
    localparam logic [DATA_WIDTH-1:0] NOP_INST = DATA_WIDTH'(32'h0000_0013);

    logic [PW-1:0]         alloc_ptr, fill_ptr, head_ptr;
    logic [PW-1:0]         drop_cnt;
    logic [PW-1:0]         used, pending;
    logic [PW:0]           occupancy, drop_sum, drop_flush;
    logic [AW-1:0]         alloc_idx, fill_idx, head_idx;
    logic                  full, do_fill, do_drop, do_pop;
    logic [DATA_WIDTH-1:0] slot_pc   [DEPTH];
    logic [DATA_WIDTH-1:0] slot_inst [DEPTH];
    logic [DEPTH-1:0]      slot_filled;

    assign used      = alloc_ptr - head_ptr;
    assign pending   = alloc_ptr - fill_ptr;
    assign alloc_idx = alloc_ptr[AW-1:0];
    assign fill_idx  = fill_ptr[AW-1:0];
    assign head_idx  = head_ptr[AW-1:0];

    // Orphaned reads still occupy memory bandwidth, so they count against capacity.
    assign occupancy = {1'b0, used} + {1'b0, drop_cnt};
    assign full      = occupancy >= OCC_FULL;

    assign imem_req_o    = rst_ni && !flush_i && !full;
    assign imem_addr_o   = pc_i;
    assign fetch_stall_o = full && !flush_i;

    assign do_drop = imem_rvalid_i && (drop_cnt != '0);
    assign do_fill = imem_rvalid_i && (drop_cnt == '0) && (pending != '0);

    // A response arriving in the flush cycle retires one of the reads being orphaned.
    assign drop_sum   = {1'b0, drop_cnt} + {1'b0, pending};
    assign drop_flush = (imem_rvalid_i && drop_sum != '0) ? drop_sum - SUM_ONE : drop_sum;

    // Decode handshake: inst_valid_o comes from registered state only and never looks at
    // inst_ready_i; a pair transfers on a clk_i edge where both are high and flush_i is low.
    assign inst_valid_o = (used != '0) && slot_filled[head_idx];
    assign inst_o       = inst_valid_o ? slot_inst[head_idx] : NOP_INST;
    assign inst_pc_o    = inst_valid_o ? slot_pc[head_idx] : '0;
    assign do_pop       = inst_valid_o && inst_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            head_ptr    <= '0;
            drop_cnt    <= '0;
            slot_filled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_pc[i]   <= '0;
                slot_inst[i] <= '0;
            end
        end else if (flush_i) begin
            head_ptr    <= alloc_ptr;
            fill_ptr    <= alloc_ptr;
            slot_filled <= '0;
            drop_cnt    <= drop_flush[PW-1:0];
        end else begin
            if (imem_req_o) begin
                slot_pc[alloc_idx]     <= pc_i;
                slot_filled[alloc_idx] <= 1'b0;
                alloc_ptr              <= alloc_ptr + PTR_ONE;
            end
            if (do_drop) begin
                drop_cnt <= drop_cnt - PTR_ONE;
            end
            // fill_idx never equals alloc_idx here: that would need pending == DEPTH, i.e. full.
            if (do_fill) begin
                slot_inst[fill_idx]   <= imem_rdata_i;
                slot_filled[fill_idx] <= 1'b1;
                fill_ptr              <= fill_ptr + PTR_ONE;
            end
            if (do_pop) begin
                head_ptr <= head_ptr + PTR_ONE;
            end
        end
    end

endmodule
